// File: rtl/core_lsu.sv
// core_lsu: load/store unit between EXEC and write-back.
// Performs one word-aligned bus access with byte-lane steering, returns the
// extended load value and reports alignment, bus-error and timeout faults.
// Every output is driven straight from a flop.
module core_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_en,
    input  logic        lsu_write,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_wb,
    output logic        lsu_fault,
    output logic [1:0]  lsu_fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
    localparam logic [1:0] CAUSE_BUSERR   = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wb_q, wb_d;
    logic             fault_q, fault_d;
    logic [1:0]       cause_q, cause_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             req_illegal, req_misal;
    logic [3:0]       st_wstrb;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_shift, ld_value;
    logic [CNT_W-1:0] cnt_inc;

    // Decode the incoming request: legality, alignment and store lane steering.
    always_comb begin
        req_illegal = 1'b0;
        req_misal   = 1'b0;
        st_wstrb    = 4'b1111;
        st_wdata    = lsu_wdata;
        case (lsu_funct3)
            3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
            3'b100, 3'b101:         req_illegal = lsu_write;  // unsigned stores do not exist
            default:                req_illegal = 1'b1;
        endcase
        // funct3[1:0] encodes the access size for every legal code.
        case (lsu_funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << lsu_addr[1:0];
                st_wdata = {4{lsu_wdata[7:0]}};
            end
            2'b01: begin
                req_misal = lsu_addr[0];
                st_wstrb  = 4'b0011 << lsu_addr[1:0];
                st_wdata  = {2{lsu_wdata[15:0]}};
            end
            default: begin
                req_misal = (lsu_addr[1:0] != 2'b00);
                st_wstrb  = 4'b1111;
                st_wdata  = lsu_wdata;
            end
        endcase
    end

    // Align the returned bus word to the addressed byte and extend to 32 bits.
    always_comb begin
        ld_shift = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_value = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_value = {24'd0, ld_shift[7:0]};
            3'b001:  ld_value = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_value = {16'd0, ld_shift[15:0]};
            default: ld_value = ld_shift;
        endcase
    end

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state logic: IDLE accepts, ACCESS waits for the bus, RESP reports for one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        f3_d    = f3_q;
        off_d   = off_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        wb_d    = wb_q;
        fault_d = fault_q;
        cause_d = cause_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_en) begin
                    write_d = lsu_write;
                    f3_d    = lsu_funct3;
                    off_d   = lsu_addr[1:0];
                    if (req_illegal || req_misal) begin
                        // Faulting requests never reach the bus.
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        cause_d = req_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                        wb_d    = 1'b0;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = S_ACCESS;
                        req_d   = 1'b1;
                        we_d    = lsu_write;
                        addr_d  = {lsu_addr[31:2], 2'b00};
                        wstrb_d = lsu_write ? st_wstrb : 4'b0000;
                        wdata_d = lsu_write ? st_wdata : 32'd0;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    // A handshake in the timeout cycle still completes normally.
                    state_d = S_RESP;
                    done_d  = 1'b1;
                    fault_d = mem_error;
                    cause_d = mem_error ? CAUSE_BUSERR : 2'd0;
                    wb_d    = !write_q && !mem_error;
                    rdata_d = (!write_q && !mem_error) ? ld_value : 32'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'd0;
                    wstrb_d = 4'b0000;
                    wdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_inc;
                    if (TO_EN && (cnt_inc == TO_LIMIT)) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        cause_d = CAUSE_TIMEOUT;
                        wb_d    = 1'b0;
                        rdata_d = 32'd0;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = 32'd0;
                        wstrb_d = 4'b0000;
                        wdata_d = 32'd0;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                wb_d    = 1'b0;
                fault_d = 1'b0;
                cause_d = 2'd0;
                rdata_d = 32'd0;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 32'd0;
            wb_q    <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= 2'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            wb_q    <= wb_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
        end
    end

    assign lsu_busy        = busy_q;
    assign lsu_done        = done_q;
    assign lsu_rdata       = rdata_q;
    assign lsu_wb          = wb_q;
    assign lsu_fault       = fault_q;
    assign lsu_fault_cause = cause_q;
    assign mem_req         = req_q;
    assign mem_we          = we_q;
    assign mem_addr        = addr_q;
    assign mem_wstrb       = wstrb_q;
    assign mem_wdata       = wdata_q;

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
- Load/store unit sitting between the EXEC stage and the write-back mux.
- Takes the effective address (rs1 + imm) and store data (rs2 value from the register file read port B).
- Performs one word-aligned access on the data bus with byte-lane steering.
- Returns the sign/zero-extended load value, which the write-back mux forwards to the register file write port. Alignment, bus-error and timeout faults are flagged to the trap logic.

Parameters:
TIMEOUT_CYCLES, 255, cycles mem_req may stay high without mem_ready before a timeout fault; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
lsu_en  input  1  start request from EXEC; sampled only in IDLE
lsu_write  input  1  1 = store, 0 = load
lsu_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_addr  input  32  effective byte address
lsu_wdata  input  32  store data, rs2 value
lsu_busy  output  1  high whenever state != IDLE
lsu_done  output  1  one-cycle completion pulse
lsu_rdata  output  32  extended load result; valid while lsu_done=1
lsu_wb  output  1  with lsu_done: result must be written back (load, no fault)
lsu_fault  output  1  with lsu_done: access faulted
lsu_fault_cause  output  2  0 misaligned, 1 bus error, 2 timeout, 3 illegal funct3
mem_req  output  1  bus request
mem_we  output  1  bus write enable
mem_addr  output  32  word address; {lsu_addr[31:2], 2'b00}
mem_wstrb  output  4  byte strobes (stores only; 0000 on loads)
mem_wdata  output  32  lane-replicated store data
mem_ready  input  1  bus handshake completion
mem_rdata  input  32  bus read data; valid with mem_ready
mem_error  input  1  bus error; meaningful only when mem_ready=1

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, timeout counter 0, internal latches 0. Reset mid-access drops mem_req immediately; no lsu_done is produced for the aborted access.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, ACCESS, RESP.
- IDLE + lsu_en=1, legal and aligned:
  - Latch the request.
  - Next cycle: ACCESS with mem_req=1, mem_we=lsu_write; mem_addr, mem_wstrb and mem_wdata computed from the latched request.
- IDLE + lsu_en=1, illegal or misaligned: no bus request; next cycle RESP with lsu_fault=1.
  - Illegal: 011, 110, 111 on any access; 100 or 101 on a store → cause 3.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0 → cause 0.
  - If both apply, cause 3 takes priority.
- lsu_en while busy: ignored. EXEC must stall on lsu_busy.
- ACCESS:
  - mem_req and all bus outputs are held stable until mem_ready.
  - mem_ready=1 → drop mem_req next cycle and enter RESP.
    - Load: latch the extracted mem_rdata.
    - mem_error=1 → fault, cause 1.
  - Counter increments each ACCESS cycle without mem_ready. When it reaches TIMEOUT_CYCLES (if non-zero): drop mem_req, enter RESP, fault cause 2.
  - mem_ready in the same cycle as the counter reaching TIMEOUT_CYCLES: mem_ready wins.
- RESP: exactly one cycle.
  - lsu_done=1. lsu_wb = !lsu_write & !fault.
  - Outputs: lsu_rdata = load result, or 0 on a store or fault.
  - Clear the counter; return to IDLE. A new lsu_en is accepted in the cycle after RESP.
- Minimum latency: lsu_en (cycle 0), mem_req (cycle 1), mem_ready in cycle 1, lsu_done (cycle 2).
- Store steering, with off = addr[1:0]:
  - SB: wdata = {4{wdata[7:0]}}, wstrb = 0001<<off.
  - SH: wdata = {2{wdata[15:0]}}, wstrb = 0011<<off.
  - SW: wstrb = 1111.
- Load extraction: shift mem_rdata right by 8*off, then:
  - B sign-extends bit 7; BU zero-extends.
  - H sign-extends bit 15; HU zero-extends.
  - W passes through.

Test Plan:
- LW addr 0x1000_0004, mem_rdata 0xDEAD_BEEF, mem_ready in first ACCESS cycle → mem_addr 0x1000_0004, mem_wstrb 0000, lsu_done at cycle 2, lsu_rdata 0xDEAD_BEEF, lsu_wb=1.
- LB addr ...03 / LBU addr ...03, mem_rdata 0x80FF_0000 → LB gives lsu_rdata 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH addr 0x2002, wdata 0x1234_ABCD, 3 wait cycles → mem_wdata 0xABCD_ABCD, wstrb 1100, mem_req held stable 4 cycles, lsu_done with lsu_wb=0, lsu_rdata 0.
- Faults without mem_req:
  - LW addr 0x2001 → lsu_done cycle 1, lsu_fault=1, cause 0, mem_req never asserted.
  - funct3 110 → cause 3, mem_req never asserted.
- TIMEOUT_CYCLES=4, mem_ready held low → mem_req drops after 4 ACCESS cycles, lsu_done with cause 2.
- Same timeout setup with mem_ready on the 4th cycle → normal completion.
- LW with mem_ready+mem_error → cause 1.
- rst_n pulsed low during ACCESS → mem_req and lsu_busy drop immediately, no lsu_done; the next LW completes normally.
